// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared flow-table sizing and ACK scheduler state encoding
package tcp_pkg;

    localparam int FLOWID_W     = 4;
    localparam int MAX_FLOW_CNT = 12;

    typedef enum logic {
        ACK_SCHED_IDLE,
        ACK_SCHED_OFFER
    } ack_sched_state_e;

endpackage

// File: rtl/ack_pending_sched_if.sv
// rtl/ack_pending_sched_if.sv - pure-ACK offer handshake between scheduler and ACK generator
interface ack_pending_sched_if
    import tcp_pkg::*;
#(
    parameter int FLOWID_W = tcp_pkg::FLOWID_W
);

    logic                sched_val;
    logic [FLOWID_W-1:0] sched_flowid;
    logic                sched_rdy;

    modport master (
        output sched_val,
        output sched_flowid,
        input  sched_rdy
    );

    modport slave (
        input  sched_val,
        input  sched_flowid,
        output sched_rdy
    );

endinterface

// File: rtl/ack_pending_sched_rr_prio_enc.sv
// rtl/ack_pending_sched_rr_prio_enc.sv - combinational round-robin priority encoder
module rr_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_val,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam logic [IDX_W:0] LIM = (IDX_W+1)'(WIDTH);

    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] rot_idx;

    // Modular add; both operands are assumed to be below WIDTH.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= LIM) begin
            s = s - LIM;
        end
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        rot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rot[i] = req[wrap_add(ptr, IDX_W'(i))];
        end
    end

    always_comb begin
        gnt_val = 1'b0;
        rot_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_val = 1'b1;
                rot_idx = IDX_W'(i);
            end
        end
    end

    assign gnt_idx = wrap_add(rot_idx, ptr);

endmodule

// File: rtl/ack_pending_sched.sv
// rtl/ack_pending_sched.sv - per-flow ACK-pending table with delayed-ACK counts and round-robin ACK offer
module ack_pending_sched
    import tcp_pkg::*;
#(
    parameter int FLOW_CNT   = MAX_FLOW_CNT,
    parameter int FLOWID_W   = tcp_pkg::FLOWID_W,
    parameter int NUM_SET    = 2,
    parameter int CNT_W      = 2,
    parameter int ACK_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SET-1:0]           set_val,
    input  logic [NUM_SET*FLOWID_W-1:0]  set_flowid,
    input  logic                         clear_val,
    input  logic [FLOWID_W-1:0]          clear_flowid,
    input  logic                         rd_val,
    input  logic [FLOWID_W-1:0]          rd_flowid,
    output logic                         rd_pending,
    output logic [CNT_W-1:0]             rd_cnt,
    input  logic                         flush,
    ack_pending_sched_if.master          sched,
    output logic                         any_pending
);

    localparam int                SUM_W    = CNT_W + $clog2(NUM_SET + 1) + 1;
    localparam logic [SUM_W-1:0]  CNT_MAX  = SUM_W'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0]  THRESH   = CNT_W'(ACK_THRESH);
    localparam logic [FLOWID_W:0] FLOW_LIM = (FLOWID_W+1)'(FLOW_CNT);
    localparam logic [FLOWID_W-1:0] LAST_ID = FLOWID_W'(FLOW_CNT - 1);

    logic [FLOW_CNT-1:0] pending, pending_nxt, eligible;
    logic [CNT_W-1:0]    cnt     [FLOW_CNT];
    logic [CNT_W-1:0]    cnt_nxt [FLOW_CNT];

    ack_sched_state_e    state, state_nxt;
    logic [FLOWID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [FLOWID_W-1:0] offer_id, offer_id_nxt;
    logic                accept;
    logic                gnt_val;
    logic [FLOWID_W-1:0] gnt_idx;
    logic                rd_hit;

    assign accept             = (state == ACK_SCHED_OFFER) && sched.sched_rdy;
    assign sched.sched_val    = (state == ACK_SCHED_OFFER);
    assign sched.sched_flowid = offer_id;

    // Clears zero the base first, so any same-cycle set hits survive the clear.
    always_comb begin
        logic [SUM_W-1:0] k;
        logic [SUM_W-1:0] sum;
        logic             clr;
        pending_nxt = '0;
        eligible    = '0;
        for (int f = 0; f < FLOW_CNT; f++) begin
            k = '0;
            for (int i = 0; i < NUM_SET; i++) begin
                if (set_val[i] && (set_flowid[i*FLOWID_W +: FLOWID_W] == FLOWID_W'(f))) begin
                    k = k + SUM_W'(1);
                end
            end
            clr = (clear_val && (clear_flowid == FLOWID_W'(f))) ||
                  (accept && (offer_id == FLOWID_W'(f)));
            sum = (clr ? '0 : SUM_W'(cnt[f])) + k;
            cnt_nxt[f]     = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
            pending_nxt[f] = (k != '0) | (pending[f] & ~clr);
            eligible[f]    = pending[f] & ((cnt[f] >= THRESH) | flush);
        end
    end

    rr_prio_enc #(
        .WIDTH (FLOW_CNT),
        .IDX_W (FLOWID_W)
    ) u_rr_prio_enc (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt_val (gnt_val),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        offer_id_nxt = offer_id;
        case (state)
            ACK_SCHED_IDLE: begin
                if (gnt_val) begin
                    state_nxt    = ACK_SCHED_OFFER;
                    offer_id_nxt = gnt_idx;
                end
            end
            ACK_SCHED_OFFER: begin
                if (sched.sched_rdy) begin
                    state_nxt  = ACK_SCHED_IDLE;
                    rr_ptr_nxt = (offer_id == LAST_ID) ? '0 : offer_id + FLOWID_W'(1);
                end
            end
            default: state_nxt = ACK_SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACK_SCHED_IDLE;
            rr_ptr   <= '0;
            offer_id <= '0;
            pending  <= '0;
            for (int f = 0; f < FLOW_CNT; f++) begin
                cnt[f] <= '0;
            end
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            offer_id <= offer_id_nxt;
            pending  <= pending_nxt;
            for (int f = 0; f < FLOW_CNT; f++) begin
                cnt[f] <= cnt_nxt[f];
            end
        end
    end

    assign rd_hit      = rd_val && ({1'b0, rd_flowid} < FLOW_LIM);
    assign rd_pending  = rd_hit ? pending[rd_flowid] : 1'b0;
    assign rd_cnt      = rd_hit ? cnt[rd_flowid] : '0;
    assign any_pending = |pending;

endmodule

// File: tb/tb_ack_pending_sched.sv
// tb/tb_ack_pending_sched.sv - self-checking bench for ack_pending_sched
module tb_ack_pending_sched;

    localparam int N  = 12;
    localparam int FW = 4;

    typedef struct {
        logic          s0v;
        logic [FW-1:0] s0id;
        logic          s1v;
        logic [FW-1:0] s1id;
        logic          cv;
        logic [FW-1:0] cid;
        logic          rv;
        logic [FW-1:0] rid;
        logic          fl;
        logic          rdy;
    } vin_t;

    typedef struct {
        vin_t          v;
        logic          e_rp;
        logic [1:0]    e_rc;
        logic          e_sv;
        logic [FW-1:0] e_sid;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    set_val;
    logic [2*FW-1:0] set_flowid;
    logic          clear_val;
    logic [FW-1:0] clear_flowid;
    logic          rd_val;
    logic [FW-1:0] rd_flowid;
    logic          rd_pending;
    logic [1:0]    rd_cnt;
    logic          flush;
    logic          any_pending;

    ack_pending_sched_if #(.FLOWID_W(FW)) sif ();

    ack_pending_sched #(
        .FLOW_CNT   (N),
        .FLOWID_W   (FW),
        .NUM_SET    (2),
        .CNT_W      (2),
        .ACK_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_val      (set_val),
        .set_flowid   (set_flowid),
        .clear_val    (clear_val),
        .clear_flowid (clear_flowid),
        .rd_val       (rd_val),
        .rd_flowid    (rd_flowid),
        .rd_pending   (rd_pending),
        .rd_cnt       (rd_cnt),
        .flush        (flush),
        .sched        (sif),
        .any_pending  (any_pending)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: flow table plus the offer currently outstanding.
    bit   m_pend [N];
    int   m_cnt  [N];
    bit   m_val;
    int   m_id;
    int   m_ptr;
    vin_t cur;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vin_t mk(input logic s0v, input int s0id, input logic s1v, input int s1id,
                                input logic cv, input int cid, input int rid,
                                input logic fl, input logic rdy);
        vin_t v;
        v.s0v = s0v; v.s0id = FW'(s0id);
        v.s1v = s1v; v.s1id = FW'(s1id);
        v.cv  = cv;  v.cid  = FW'(cid);
        v.rv  = 1'b1; v.rid = FW'(rid);
        v.fl  = fl;  v.rdy  = rdy;
        return v;
    endfunction

    function automatic vec_t row(input vin_t v, input logic rp, input int rc,
                                 input logic sv, input int sid);
        vec_t r;
        r.v = v; r.e_rp = rp; r.e_rc = 2'(rc); r.e_sv = sv; r.e_sid = FW'(sid);
        return r;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < N; f++) begin
            m_pend[f] = 1'b0;
            m_cnt[f]  = 0;
        end
        m_val = 1'b0;
        m_id  = 0;
        m_ptr = 0;
    endtask

    task automatic model_step(input vin_t v);
        bit acc;
        bit found;
        int k, c, idx;
        bit clr;
        acc = m_val && v.rdy;
        if (m_val) begin
            if (v.rdy) begin
                m_val = 1'b0;
                m_ptr = (m_id + 1) % N;
            end
        end else begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                idx = (m_ptr + j) % N;
                if (!found && m_pend[idx] && (m_cnt[idx] >= 2 || v.fl)) begin
                    found = 1'b1;
                    m_val = 1'b1;
                    m_id  = idx;
                end
            end
        end
        for (int f = 0; f < N; f++) begin
            k = 0;
            if (v.s0v && int'(v.s0id) == f) k++;
            if (v.s1v && int'(v.s1id) == f) k++;
            clr = (v.cv && int'(v.cid) == f) || (acc && m_id == f);
            c = (clr ? 0 : m_cnt[f]) + k;
            m_cnt[f]  = (c > 3) ? 3 : c;
            m_pend[f] = clr ? (k != 0) : (m_pend[f] || k != 0);
        end
    endtask

    task automatic drive(input vin_t v);
        int  exp_rp, exp_rc;
        bit  exp_any;
        @(negedge clk);
        cur           = v;
        set_val       = {v.s1v, v.s0v};
        set_flowid    = {v.s1id, v.s0id};
        clear_val     = v.cv;
        clear_flowid  = v.cid;
        rd_val        = v.rv;
        rd_flowid     = v.rid;
        flush         = v.fl;
        sif.sched_rdy = v.rdy;
        #1;
        exp_rp  = (v.rv && int'(v.rid) < N) ? int'(m_pend[int'(v.rid)]) : 0;
        exp_rc  = (v.rv && int'(v.rid) < N) ? m_cnt[int'(v.rid)] : 0;
        exp_any = 1'b0;
        for (int f = 0; f < N; f++) exp_any |= m_pend[f];
        chk("rd_pending", int'(rd_pending), exp_rp);
        chk("rd_cnt", int'(rd_cnt), exp_rc);
        chk("any_pending", int'(any_pending), int'(exp_any));
        chk("sched_val", int'(sif.sched_val), int'(m_val));
        if (m_val) chk("sched_flowid", int'(sif.sched_flowid), m_id);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(cur);
    endtask

    task automatic cyc(input vin_t v);
        drive(v);
        tick();
    endtask

    task automatic do_reset(input string tag, input int rid);
        rst_n     = 1'b0;
        rd_val    = 1'b1;
        rd_flowid = FW'(rid);
        #1;
        chk({tag, "_sched_val"}, int'(sif.sched_val), 0);
        chk({tag, "_sched_flowid"}, int'(sif.sched_flowid), 0);
        chk({tag, "_any_pending"}, int'(any_pending), 0);
        chk({tag, "_rd_pending"}, int'(rd_pending), 0);
        chk({tag, "_rd_cnt"}, int'(rd_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];
    int   got[$];
    int   exp_order[4] = '{1, 9, 11, 1};

    initial begin
        vin_t v;
        bit   resend, resent, prev_sv, seen;
        int   w, pick;

        rst_n = 1'b0;
        set_val = '0; set_flowid = '0; clear_val = 1'b0; clear_flowid = '0;
        rd_val = 1'b0; rd_flowid = '0; flush = 1'b0; sif.sched_rdy = 1'b0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        do_reset("por", 5);

        // Flow 5 threshold/offer/hold/accept, then rr_ptr and flush checks
        tbl.push_back(row(mk(1, 5, 0, 0, 0, 0, 5, 0, 0), 0, 0, 0, 0));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 5, 0, 0), 1, 1, 0, 0));
        tbl.push_back(row(mk(1, 5, 0, 0, 0, 0, 5, 0, 0), 1, 1, 0, 0));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 5, 0, 0), 1, 2, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 5, 0, 0), 1, 2, 1, 5));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 5, 0, 1), 1, 2, 1, 5));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 5, 0, 0), 0, 0, 0, 0));
        tbl.push_back(row(mk(1, 2, 1, 7, 0, 0, 7, 1, 0), 0, 0, 0, 0));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 7, 1, 0), 1, 1, 0, 0));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 7, 1, 1), 1, 1, 1, 7));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 2, 1, 0), 1, 1, 0, 0));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 2, 0, 1), 1, 1, 1, 2));
        tbl.push_back(row(mk(0, 0, 0, 0, 0, 0, 2, 0, 0), 0, 0, 0, 0));
        tbl.push_back(row(mk(1, 14, 0, 0, 0, 0, 13, 0, 0), 0, 0, 0, 0));
        tbl.push_back(row(mk(0, 0, 0, 0, 1, 14, 14, 0, 0), 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].v);
            chk($sformatf("tbl%0d_rd_pending", i), int'(rd_pending), int'(tbl[i].e_rp));
            chk($sformatf("tbl%0d_rd_cnt", i), int'(rd_cnt), int'(tbl[i].e_rc));
            chk($sformatf("tbl%0d_sched_val", i), int'(sif.sched_val), int'(tbl[i].e_sv));
            if (tbl[i].e_sv)
                chk($sformatf("tbl%0d_sched_flowid", i), int'(sif.sched_flowid), int'(tbl[i].e_sid));
            tick();
        end

        // Two lanes set flow 3 in the same cycle as a clear of flow 3
        cyc(mk(1, 3, 0, 0, 0, 0, 3, 0, 0));
        cyc(mk(1, 3, 1, 3, 1, 3, 3, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 3, 0, 0));
        chk("setclr_pending", int'(rd_pending), 1);
        chk("setclr_cnt", int'(rd_cnt), 2);
        tick();
        cyc(mk(0, 0, 0, 0, 0, 0, 3, 0, 1));
        cyc(mk(0, 0, 0, 0, 0, 0, 3, 0, 0));

        // Five sets on flow 7 saturate at 3
        cyc(mk(1, 7, 1, 7, 0, 0, 7, 0, 0));
        drive(mk(1, 7, 1, 7, 0, 0, 7, 0, 0));
        chk("sat_cnt_2", int'(rd_cnt), 2);
        tick();
        drive(mk(1, 7, 0, 0, 0, 0, 7, 0, 0));
        chk("sat_cnt_4", int'(rd_cnt), 3);
        tick();
        drive(mk(0, 0, 0, 0, 0, 0, 7, 0, 0));
        chk("sat_cnt_5", int'(rd_cnt), 3);
        tick();
        cyc(mk(0, 0, 0, 0, 0, 0, 7, 0, 1));
        cyc(mk(0, 0, 0, 0, 0, 0, 7, 0, 0));

        // Flush round robin over 1, 9, 11 and back to 1
        @(negedge clk);
        #2;
        do_reset("rst2", 1);
        cyc(mk(1, 1, 1, 9, 0, 0, 1, 0, 0));
        cyc(mk(1, 11, 0, 0, 0, 0, 11, 0, 0));
        resend = 1'b0; resent = 1'b0; prev_sv = 1'b0;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            drive(mk(0, 0, resend, 1, 0, 0, 1, 1, 1));
            if (prev_sv) chk("flush_idle_gap", int'(sif.sched_val), 0);
            prev_sv = sif.sched_val;
            resend  = 1'b0;
            if (sif.sched_val) begin
                got.push_back(int'(sif.sched_flowid));
                if (!resent) begin
                    resend = 1'b1;
                    resent = 1'b1;
                end
            end
            tick();
        end
        chk("flush_offer_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk($sformatf("flush_order%0d", i), got[i], exp_order[i]);
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Accept flow 4 while lane 1 sets it, then reset mid-offer
        cyc(mk(1, 4, 0, 0, 0, 0, 4, 0, 0));
        cyc(mk(1, 4, 0, 0, 0, 0, 4, 0, 0));
        w = 0; seen = 1'b0;
        do begin
            drive(mk(0, 0, 0, 0, 0, 0, 4, 0, 0));
            seen = sif.sched_val;
            w++;
            if (!seen) tick();
        end while (!seen && w < 10);
        chk("offer4_seen", int'(seen), 1);
        tick();
        cyc(mk(0, 0, 1, 4, 0, 0, 4, 0, 1));
        drive(mk(0, 0, 0, 0, 0, 0, 4, 0, 0));
        chk("acc_set_pending", int'(rd_pending), 1);
        chk("acc_set_cnt", int'(rd_cnt), 1);
        tick();
        cyc(mk(1, 4, 0, 0, 0, 0, 4, 0, 0));
        cyc(mk(0, 0, 0, 0, 0, 0, 4, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 4, 0, 0));
        chk("offer4_again", int'(sif.sched_val), 1);
        #2;
        do_reset("midoffer", 4);

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            v.s0v  = 1'($urandom_range(0, 1));
            v.s0id = FW'($urandom_range(0, 13));
            v.s1v  = 1'($urandom_range(0, 1));
            v.s1id = FW'($urandom_range(0, 13));
            v.cv   = ($urandom_range(0, 3) == 0);
            v.cid  = FW'($urandom_range(0, 13));
            v.rv   = ($urandom_range(0, 3) != 0);
            v.rid  = FW'($urandom_range(0, 15));
            v.fl   = ($urandom_range(0, 7) == 0);
            v.rdy  = 1'($urandom_range(0, 1));
            cyc(v);
        end

        // Reset with the table loaded
        pick = 0;
        for (int f = N - 1; f >= 0; f--) if (m_pend[f]) pick = f;
        @(negedge clk);
        #3;
        do_reset("loaded", pick);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
